// File: rtl/rx_slicer_pkg.sv
// Shared types and constants for the RX slicer / PRBS7 checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rx_slicer_pkg;

    // Checker FSM: SEED fills the predictor, CHECK compares against it.
    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } state_t;

    // PRBS7, x^7 + x^6 + 1: the next bit is the XOR of the bits
    // received 7 and 6 UIs ago (lfsr[6] and lfsr[5] with LSB-in shifting).
    localparam int PRBS_ORDER  = 7;
    localparam int PRBS_TAP_A  = 6;
    localparam int PRBS_TAP_B  = 5;

    function automatic logic prbs7_pred(input logic [PRBS_ORDER-1:0] s);
        return s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
    endfunction

endpackage

// File: rtl/rx_slicer_prbs_checker_prbs7.sv
// PRBS7 predictor: history register of received bits plus seed counter.
// Latency: pred/seeded reflect all bits shifted up to the previous edge.
// Backpressure: none; shifts whenever shift is high.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   shift     - advance by one received bit
//   bit_in    - received bit (shifted into lfsr[0])
//   reseed    - restart the seed count (lfsr content is kept)
//   pred      - predicted value of the next received bit
//   seeded    - PRBS_ORDER bits shifted in since the last reset/reseed
module prbs7_predictor
    import rx_slicer_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic bit_in,
    input  logic reseed,
    output logic pred,
    output logic seeded
);

    localparam int SEED_W = $clog2(PRBS_ORDER + 1);

    logic [PRBS_ORDER-1:0] lfsr;
    logic [SEED_W-1:0]     seed_cnt;

    // The received bit is shifted in, not the prediction, so the
    // predictor re-aligns itself after any bit error.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= '0;
            seed_cnt <= '0;
        end else begin
            if (shift) begin
                lfsr <= {lfsr[PRBS_ORDER-2:0], bit_in};
            end
            if (reseed) begin
                seed_cnt <= '0;
            end else if (shift && !seeded) begin
                seed_cnt <= seed_cnt + SEED_W'(1);
            end
        end
    end

    assign seeded = (seed_cnt == SEED_W'(PRBS_ORDER));
    assign pred   = prbs7_pred(lfsr);

endmodule

// File: rtl/rx_slicer_prbs_checker.sv
// RX slicer + self-synchronising PRBS7 checker on a fixed-point CTLE output.
// Latency: bit_out/bit_valid 1 cycle after the sampling strobe; err_pulse with bit_valid, err_cnt 1 later.
// Backpressure: none; en gates the UI counter (sampling pauses, state is kept).
//
// Optional build macro SLICER_HYST_EN: slicer with +/-HYST LSB hysteresis band.
//
// Ports:
//   emu_clk, emu_rst - emulator clock, synchronous active-high reset
//   v_in             - signed CTLE output voltage, LSB = 2^V_EXPONENT V
//   en               - UI counter advances only while high
//   clr_err          - synchronous clear of err_cnt (wins over an increment)
//   bit_out          - last sliced bit
//   bit_valid        - 1-cycle pulse when bit_out updates
//   locked           - PRBS predictor locked
//   err_pulse        - mismatch while locked, coincident with bit_valid
//   err_cnt          - saturating count of err_pulse
module rx_slicer_prbs_checker
    import rx_slicer_pkg::*;
#(
    parameter int V_WIDTH       = 18,
    parameter int V_EXPONENT    = -12,
    parameter int UI_CYCLES     = 16,
    parameter int SAMPLE_OFFSET = 8,
    parameter int WIN_BITS      = 32,
    parameter int ERR_LIMIT     = 8,
    parameter int ERR_WIDTH     = 32,
    parameter int HYST          = 16
)(
    input  logic                        emu_clk,
    input  logic                        emu_rst,
    input  logic signed [V_WIDTH-1:0]   v_in,
    input  logic                        en,
    input  logic                        clr_err,
    output logic                        bit_out,
    output logic                        bit_valid,
    output logic                        locked,
    output logic                        err_pulse,
    output logic [ERR_WIDTH-1:0]        err_cnt
);

    localparam int UI_W   = (UI_CYCLES > 1) ? $clog2(UI_CYCLES) : 1;
    localparam int WIN_W  = $clog2(WIN_BITS + 1);
    localparam int ERRL_W = $clog2(ERR_LIMIT + 1);

    // Elaboration-time guard. The threshold sits at 0 V, so the input is
    // expected to carry a fractional part (negative exponent).
    generate
        if (UI_CYCLES < 2 || SAMPLE_OFFSET < 0 || SAMPLE_OFFSET >= UI_CYCLES ||
            WIN_BITS < 1 || ERR_LIMIT < 1 || ERR_WIDTH < 1 || V_WIDTH < 2 ||
            HYST < 0 || V_EXPONENT >= 0) begin : g_bad_cfg
            $error("rx_slicer_prbs_checker: illegal parameter combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // UI timing
    // ------------------------------------------------------------------
    logic [UI_W-1:0] ui_cnt;
    logic            strobe;

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            ui_cnt <= '0;
        end else if (en) begin
            ui_cnt <= (ui_cnt == UI_W'(UI_CYCLES - 1)) ? '0 : ui_cnt + UI_W'(1);
        end
    end

    assign strobe = en && (ui_cnt == UI_W'(SAMPLE_OFFSET));

    // ------------------------------------------------------------------
    // Slicer
    // ------------------------------------------------------------------
    logic slice_bit;

`ifdef SLICER_HYST_EN
    localparam logic signed [V_WIDTH-1:0] HYST_HI = V_WIDTH'(HYST);
    localparam logic signed [V_WIDTH-1:0] HYST_LO = -HYST_HI;

    // Inside the band the previous decision is repeated; bit_out is that
    // previous decision and resets to 0.
    always_comb begin
        slice_bit = bit_out;
        if (v_in > HYST_HI) begin
            slice_bit = 1'b1;
        end else if (v_in < HYST_LO) begin
            slice_bit = 1'b0;
        end
    end
`else
    localparam logic signed [V_WIDTH-1:0] V_ZERO = '0;

    // Exactly 0 V slices to 0.
    assign slice_bit = (v_in > V_ZERO);
`endif

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= strobe;
            if (strobe) begin
                bit_out <= slice_bit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Predictor: consumes each registered bit on its bit_valid cycle
    // ------------------------------------------------------------------
    logic pred;
    logic seeded;
    logic lose;

    prbs7_predictor u_pred (
        .clk    (emu_clk),
        .rst    (emu_rst),
        .shift  (bit_valid),
        .bit_in (bit_out),
        .reseed (lose),
        .pred   (pred),
        .seeded (seeded)
    );

    // ------------------------------------------------------------------
    // FSM and lock window
    // ------------------------------------------------------------------
    state_t            state;
    state_t            state_nxt;
    logic              checking;
    logic              mismatch;
    logic              win_done;
    logic [WIN_W-1:0]  win_cnt;
    logic [WIN_W-1:0]  win_cnt_nxt;
    logic [ERRL_W-1:0] win_err;
    logic [ERRL_W-1:0] win_err_nxt;

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

    // SEED->CHECK happens the cycle after the last seed bit; bits are at
    // least two cycles apart, so CHECK is in place for the next bit.
    always_comb begin
        state_nxt = state;
        case (state)
            SEED:    if (seeded) state_nxt = CHECK;
            CHECK:   if (lose)   state_nxt = SEED;
            default: state_nxt = SEED;
        endcase
    end

    always_comb begin
        checking    = (state == CHECK);
        mismatch    = checking && (bit_out != pred);
        win_cnt_nxt = win_cnt + WIN_W'(1);
        win_err_nxt = win_err + ERRL_W'(mismatch);
        // Loss of lock may happen mid-window and takes priority.
        lose        = bit_valid && checking && (win_err_nxt == ERRL_W'(ERR_LIMIT));
        win_done    = bit_valid && checking && !lose && (win_cnt_nxt == WIN_W'(WIN_BITS));
        err_pulse   = bit_valid && locked && mismatch;
    end

    // The window is held clear while seeding, so CHECK always starts fresh.
    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (!checking || lose || win_done) begin
            win_cnt <= '0;
            win_err <= '0;
        end else if (bit_valid) begin
            win_cnt <= win_cnt_nxt;
            win_err <= win_err_nxt;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            locked <= 1'b0;
        end else if (lose) begin
            locked <= 1'b0;
        end else if (win_done && (win_err_nxt == '0)) begin
            locked <= 1'b1;
        end
    end

    always_ff @(posedge emu_clk) begin
        if (emu_rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (err_pulse && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_rx_slicer_prbs_checker.sv
// Self-checking bench for rx_slicer_prbs_checker (scoreboard of per-bit expectations).
// Latency: n/a.
// Backpressure: n/a.
module tb_rx_slicer_prbs_checker;

    localparam int V_WIDTH       = 18;
    localparam int V_EXPONENT    = -12;
    localparam int UI_CYCLES     = 16;
    localparam int SAMPLE_OFFSET = 8;
    localparam int WIN_BITS      = 32;
    localparam int ERR_LIMIT     = 8;
    localparam int ERR_WIDTH     = 32;
    localparam int HYST          = 16;

    localparam logic signed [V_WIDTH-1:0] ONE_V = V_WIDTH'(1 << (-V_EXPONENT));

    logic                       emu_clk = 1'b0;
    logic                       emu_rst;
    logic signed [V_WIDTH-1:0]  v_in;
    logic                       en;
    logic                       clr_err;
    logic                       bit_out;
    logic                       bit_valid;
    logic                       locked;
    logic                       err_pulse;
    logic [ERR_WIDTH-1:0]       err_cnt;

    rx_slicer_prbs_checker #(
        .V_WIDTH       (V_WIDTH),
        .V_EXPONENT    (V_EXPONENT),
        .UI_CYCLES     (UI_CYCLES),
        .SAMPLE_OFFSET (SAMPLE_OFFSET),
        .WIN_BITS      (WIN_BITS),
        .ERR_LIMIT     (ERR_LIMIT),
        .ERR_WIDTH     (ERR_WIDTH),
        .HYST          (HYST)
    ) dut (
        .emu_clk   (emu_clk),
        .emu_rst   (emu_rst),
        .v_in      (v_in),
        .en        (en),
        .clr_err   (clr_err),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 emu_clk = ~emu_clk;

    typedef struct {
        logic                 b;
        logic                 err;
        logic                 lk;
        logic [ERR_WIDTH-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Bit-level reference model state
    logic                 m_check;
    int                   m_seed;
    int                   m_wcnt;
    int                   m_werr;
    logic                 m_locked;
    logic [ERR_WIDTH-1:0] m_cnt;
    logic [6:0]           m_hist;   // m_hist[0] = most recent received bit
`ifdef SLICER_HYST_EN
    logic                 m_prev;
`endif
    logic [6:0]           gen;

    int ramp_v [12] = '{4096, -4096, 4096, 0, 1, -1, 10, -4096, 10, 17, -10, -17};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_check  = 1'b0;
        m_seed   = 0;
        m_wcnt   = 0;
        m_werr   = 0;
        m_locked = 1'b0;
        m_cnt    = '0;
        m_hist   = '0;
`ifdef SLICER_HYST_EN
        m_prev   = 1'b0;
`endif
        sb.delete();
    endtask

    task automatic slice_model(input logic signed [V_WIDTH-1:0] v, output logic b);
`ifdef SLICER_HYST_EN
        if (v > HYST)       b = 1'b1;
        else if (v < -HYST) b = 1'b0;
        else                b = m_prev;
        m_prev = b;
`else
        b = (v > 0);
`endif
    endtask

    // Expected observation for one received bit, taken before it updates the model.
    task automatic model_bit(input logic b, input logic clr);
        exp_t e;
        logic pred;
        logic mism;
        e.b   = b;
        e.err = 1'b0;
        e.lk  = m_locked;
        e.cnt = m_cnt;
        if (m_check) begin
            pred   = m_hist[6] ^ m_hist[5];
            mism   = (b != pred);
            e.err  = m_locked && mism;
            m_wcnt = m_wcnt + 1;
            m_werr = m_werr + int'(mism);
            if (m_werr == ERR_LIMIT) begin
                m_locked = 1'b0;
                m_check  = 1'b0;
                m_seed   = 0;
                m_wcnt   = 0;
                m_werr   = 0;
            end else if (m_wcnt == WIN_BITS) begin
                if (m_werr == 0) m_locked = 1'b1;
                m_wcnt = 0;
                m_werr = 0;
            end
        end else begin
            m_seed = m_seed + 1;
            if (m_seed == 7) begin
                m_check = 1'b1;
                m_wcnt  = 0;
                m_werr  = 0;
            end
        end
        m_hist = {m_hist[5:0], b};
        if (clr)                        m_cnt = '0;
        else if (e.err && m_cnt != '1)  m_cnt = m_cnt + 1'b1;
        sb.push_back(e);
    endtask

    // One clock; sample 1 time unit after the edge and score any new bit.
    task automatic cyc();
        exp_t e;
        @(posedge emu_clk);
        #1;
        if (bit_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_bit_valid", 32'(bit_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("bit_out",   32'(bit_out),   32'(e.b));
                chk("err_pulse", 32'(err_pulse), 32'(e.err));
                chk("locked",    32'(locked),    32'(e.lk));
                chk("err_cnt",   err_cnt,        e.cnt);
            end
        end else begin
            chk("err_pulse_idle", 32'(err_pulse), 32'd0);
        end
    endtask

    // One UI of stimulus; optional clr_err in the bit_valid cycle and an
    // en-low pause inserted before the sampling point.
    task automatic send_ui(input logic signed [V_WIDTH-1:0] v, input logic clr, input int pause);
        logic b;
        slice_model(v, b);
        v_in = v;
        model_bit(b, clr);
        for (int i = 1; i <= UI_CYCLES; i++) begin
            if (i == 5 && pause > 0) begin
                en = 1'b0;
                for (int p = 0; p < pause; p++) begin
                    cyc();
                    chk("bit_valid_paused", 32'(bit_valid), 32'd0);
                end
                en = 1'b1;
            end
            cyc();
            chk("bit_valid_timing", 32'(bit_valid), 32'(i == SAMPLE_OFFSET + 1));
            clr_err = (i == SAMPLE_OFFSET + 1) ? clr : 1'b0;
        end
    endtask

    task automatic prbs_bit(output logic b);
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
    endtask

    function automatic logic signed [V_WIDTH-1:0] volt(input logic b);
        return b ? ONE_V : -ONE_V;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_bit_out"},   32'(bit_out),   32'd0);
        chk({tag, "_bit_valid"}, 32'(bit_valid), 32'd0);
        chk({tag, "_locked"},    32'(locked),    32'd0);
        chk({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        chk({tag, "_err_cnt"},   err_cnt,        32'd0);
    endtask

    task automatic do_reset();
        emu_rst = 1'b1;
        en      = 1'b0;
        clr_err = 1'b0;
        v_in    = '0;
        sb.delete();
        cyc();
        cyc();
        check_all_zero("reset");
        emu_rst = 1'b0;
        en      = 1'b1;
        model_reset();
    endtask

    initial begin
        logic b;

        // Reset state
        do_reset();

        // Slicer ramp through +/- including 0 V and near-threshold values
        foreach (ramp_v[i]) send_ui(V_WIDTH'(ramp_v[i]), 1'b0, 0);

        // Clean PRBS7: lock after 7 seed + 32 window bits, no errors
        do_reset();
        gen = 7'h7F;
        for (int n = 1; n <= 1000; n++) begin
            prbs_bit(b);
            send_ui(volt(b), 1'b0, 0);
            if (n == 38) chk("locked_after_38", 32'(locked), 32'd0);
            if (n == 39) chk("locked_after_39", 32'(locked), 32'd1);
        end
        chk("prbs_locked", 32'(locked), 32'd1);
        chk("prbs_err_cnt", err_cnt, 32'd0);

        // Three isolated inversions while locked: 3 errors each
        for (int k = 0; k < 200; k++) begin
            prbs_bit(b);
            send_ui(volt((k == 10 || k == 74 || k == 138) ? ~b : b), 1'b0, 0);
        end
        chk("inv_err_cnt", err_cnt, 32'd9);
        chk("inv_locked", 32'(locked), 32'd1);

        // en low mid-UI: no strobe while paused, no bit lost
        for (int k = 0; k < 4; k++) begin
            prbs_bit(b);
            send_ui(volt(b), 1'b0, (k == 1) ? 10 : 0);
        end

        // clr_err on an error-free bit, then clr_err coincident with the 6th pulse
        prbs_bit(b);
        send_ui(volt(b), 1'b1, 0);
        chk("clr_plain", err_cnt, 32'd0);
        for (int k = 0; k < 120; k++) begin
            prbs_bit(b);
            send_ui(volt((k == 10 || k == 74) ? ~b : b), (k == 81), 0);
            if (k == 80) chk("err_cnt_before_clr", err_cnt, 32'd5);
            if (k == 81) chk("clr_wins", err_cnt, 32'd0);
        end
        chk("clr_locked", 32'(locked), 32'd1);

        // Random data: lock drops
        for (int k = 0; k < 96; k++) begin
            b = 1'($urandom_range(0, 1));
            send_ui(volt(b), 1'b0, 0);
        end
        chk("random_unlocked", 32'(locked), 32'd0);

        // Restore PRBS7: relock
        for (int k = 0; k < 150; k++) begin
            prbs_bit(b);
            send_ui(volt(b), 1'b0, 0);
        end
        chk("relocked", 32'(locked), 32'd1);
        chk("relock_err_cnt_kept", 32'(err_cnt >= ERR_WIDTH'(ERR_LIMIT)), 32'd1);

        // emu_rst pulsed mid-UI: every output back to 0 next cycle
        prbs_bit(b);
        v_in = volt(b);
        for (int i = 0; i < 5; i++) cyc();
        emu_rst = 1'b1;
        cyc();
        check_all_zero("midrst");
        emu_rst = 1'b0;
        model_reset();

        // Constant 0 input: no errors, still locks
        for (int k = 0; k < 45; k++) send_ui(-ONE_V, 1'b0, 0);
        chk("const0_locked", 32'(locked), 32'd1);
        chk("const0_err_cnt", err_cnt, 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
